// File: rtl/last_value_predictor.sv
// Last-value load predictor: direct-mapped value table with confidence counters plus an
// in-order FIFO of in-flight loads that is verified against returning cache data.
module last_value_predictor #(
  parameter int unsigned INDEX_WIDTH = 6,
  parameter int unsigned CONF_WIDTH  = 2,
  parameter int unsigned CONF_THRESH = 2,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vp_en,
  input  logic                  flush,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_pc,
  output logic                  req_ready,
  output logic                  pred_valid,
  output logic [DATA_WIDTH-1:0] pred_data,
  input  logic                  resolve_valid,
  input  logic [DATA_WIDTH-1:0] resolve_data,
  output logic                  correct,
  output logic                  mispredict,
  output logic [ADDR_WIDTH-1:0] mispredict_pc
);

  localparam int unsigned Entries  = 1 << INDEX_WIDTH;
  localparam int unsigned TagWidth = ADDR_WIDTH - INDEX_WIDTH - 2;
  localparam int unsigned PtrWidth = $clog2(DEPTH);
  localparam logic [CONF_WIDTH-1:0] ConfMax    = '1;
  localparam logic [CONF_WIDTH-1:0] ConfThresh = CONF_WIDTH'(CONF_THRESH);
  localparam logic [PtrWidth:0]     DepthCount = (PtrWidth + 1)'(DEPTH);

  logic [Entries-1:0]    tbl_valid_q;
  logic [TagWidth-1:0]   tbl_tag_q   [Entries];
  logic [DATA_WIDTH-1:0] tbl_value_q [Entries];
  logic [CONF_WIDTH-1:0] tbl_conf_q  [Entries];

  logic [ADDR_WIDTH-1:0] fifo_pc_q    [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_value_q [DEPTH];
  logic [DEPTH-1:0]      fifo_pred_q;
  logic [PtrWidth-1:0]   rd_ptr_q, wr_ptr_q;
  logic [PtrWidth:0]     count_q;

  logic                  pred_valid_q, correct_q, mispredict_q;
  logic [DATA_WIDTH-1:0] pred_data_q;
  logic [ADDR_WIDTH-1:0] mispredict_pc_q;

  logic [INDEX_WIDTH-1:0] req_idx, head_idx;
  logic [TagWidth-1:0]    req_tag, head_tag;
  logic [ADDR_WIDTH-1:0]  head_pc;
  logic [DATA_WIDTH-1:0]  head_value;
  logic                   head_pred, full, empty, pop, accept, value_match, mispredict_now;
  logic                   req_hit, predict, train_match;
  logic                   conf_inc, conf_clr, value_wr, entry_alloc;

  assign req_idx    = req_pc[INDEX_WIDTH+1:2];
  assign req_tag    = req_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign head_pc    = fifo_pc_q[rd_ptr_q];
  assign head_value = fifo_value_q[rd_ptr_q];
  assign head_pred  = fifo_pred_q[rd_ptr_q];
  assign head_idx   = head_pc[INDEX_WIDTH+1:2];
  assign head_tag   = head_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];

  assign full      = (count_q == DepthCount);
  assign empty     = (count_q == '0);
  assign req_ready = ~full;

  // A resolve arriving with flush is dropped; a resolve on an empty FIFO is ignored.
  assign pop            = resolve_valid & ~empty & ~flush;
  assign value_match    = (resolve_data == head_value);
  assign mispredict_now = pop & head_pred & ~value_match;
  assign accept         = req_valid & req_ready & ~flush & ~mispredict_now;

  assign req_hit     = tbl_valid_q[req_idx] & (tbl_tag_q[req_idx] == req_tag);
  assign predict     = req_hit & (tbl_conf_q[req_idx] >= ConfThresh) & vp_en;
  assign train_match = tbl_valid_q[head_idx] & (tbl_tag_q[head_idx] == head_tag) &
                       (tbl_value_q[head_idx] == resolve_data);

  always_comb begin
    conf_inc    = 1'b0;
    conf_clr    = 1'b0;
    value_wr    = 1'b0;
    entry_alloc = 1'b0;
    if (pop) begin
      if (head_pred) begin
        if (value_match) begin
          conf_inc = 1'b1;
        end else begin
          value_wr = 1'b1;
          conf_clr = 1'b1;
        end
      end else if (train_match) begin
        conf_inc = 1'b1;
      end else begin
        entry_alloc = 1'b1;
        value_wr    = 1'b1;
        conf_clr    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tbl_valid_q <= '0;
      for (int i = 0; i < Entries; i++) begin
        tbl_conf_q[i] <= '0;
      end
    end else begin
      if (entry_alloc) begin
        tbl_valid_q[head_idx] <= 1'b1;
      end
      if (conf_clr) begin
        tbl_conf_q[head_idx] <= '0;
      end else if (conf_inc && tbl_conf_q[head_idx] != ConfMax) begin
        tbl_conf_q[head_idx] <= tbl_conf_q[head_idx] + CONF_WIDTH'(1);
      end
    end
  end

  // Tag and value are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (entry_alloc) begin
      tbl_tag_q[head_idx] <= head_tag;
    end
    if (value_wr) begin
      tbl_value_q[head_idx] <= resolve_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush || mispredict_now) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
      end
      if (accept) begin
        wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
      end
      if (accept && !pop) begin
        count_q <= count_q + (PtrWidth + 1)'(1);
      end else if (pop && !accept) begin
        count_q <= count_q - (PtrWidth + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_pc_q[wr_ptr_q]    <= req_pc;
      fifo_pred_q[wr_ptr_q]  <= predict;
      fifo_value_q[wr_ptr_q] <= tbl_value_q[req_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pred_valid_q    <= 1'b0;
      pred_data_q     <= '0;
      correct_q       <= 1'b0;
      mispredict_q    <= 1'b0;
      mispredict_pc_q <= '0;
    end else begin
      pred_valid_q <= accept & predict;
      pred_data_q  <= (accept & predict) ? tbl_value_q[req_idx] : '0;
      correct_q    <= pop & head_pred & value_match;
      mispredict_q <= mispredict_now;
      if (mispredict_now) begin
        mispredict_pc_q <= head_pc;
      end
    end
  end

  assign pred_valid    = pred_valid_q;
  assign pred_data     = pred_data_q;
  assign correct       = correct_q;
  assign mispredict    = mispredict_q;
  assign mispredict_pc = mispredict_pc_q;

endmodule
